// File: rtl/multicycle_ctrl.sv
// Main control FSM for the MiniMIPS multi-cycle datapath.
// Sequences fetch/decode/execute/memory/writeback, owns the memory
// request handshake with a wait timeout, and counts retired instructions.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_FETCH  | instruction read request, wait for mem_ack
//   S_DECODE | one cycle to classify opcode (halt / illegal / execute)
//   S_EXEC   | ALU operation; beq resolves and retires here
//   S_MEM    | data read (lw) or write (sw) request, wait for mem_ack
//   S_WB     | register-file write, then retire
//   S_HALT   | terminal after opcode 1111
//   S_ERR    | terminal after illegal opcode or memory timeout
module multicycle_ctrl #(
    parameter int RET_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic [2:0]       ALUOp,
    output logic             alu_src_b,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [RET_W-1:0] retired
);

    // Wait timer is a down-counter: loaded with TIMEOUT-1 on entry to a
    // request state, terminal count at zero equals "waited TIMEOUT-1 cycles".
    localparam int            CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;

    logic is_r, is_imm, is_lw, is_sw, is_beq, is_halt, is_bad;
    logic in_req, wait_tc;

    assign is_r    = (opcode == 4'h0);
    assign is_imm  = (opcode[3] == 1'b0) && (opcode != 4'h0);
    assign is_lw   = (opcode == 4'h8);
    assign is_sw   = (opcode == 4'h9);
    assign is_beq  = (opcode == 4'hA);
    assign is_halt = (opcode == 4'hF);
    assign is_bad  = (opcode >= 4'hB) && (opcode <= 4'hE);

    assign in_req  = (state == S_FETCH) || (state == S_MEM);
    assign wait_tc = (wait_cnt == '0);

    // Ack/zero-qualified strobes are combinational on top of the state.
    assign ir_write  = (state == S_FETCH) && mem_ack;
    assign pc_write  = (state == S_FETCH) && mem_ack;
    assign pc_branch = (state == S_EXEC) && is_beq && zero;

    // Next-state selection.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start) nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ack)      nxt = S_DECODE;
                else if (wait_tc) nxt = S_ERR;
            end
            S_DECODE: begin
                if (is_halt)     nxt = S_HALT;
                else if (is_bad) nxt = S_ERR;
                else             nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_lw || is_sw) nxt = S_MEM;
                else if (is_beq)    nxt = S_FETCH;
                else                nxt = S_WB;
            end
            S_MEM: begin
                if (mem_ack)      nxt = is_sw ? S_FETCH : S_WB;
                else if (wait_tc) nxt = S_ERR;
            end
            S_WB:     nxt = S_FETCH;
            default:  nxt = state;
        endcase
    end

    // State, wait timer, sticky flags, retire counter and registered
    // Moore outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ALUOp      <= 3'b000;
            alu_src_b  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            reg_write  <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
            retired    <= '0;
        end else begin
            state <= nxt;

            if ((nxt != state) && ((nxt == S_FETCH) || (nxt == S_MEM)))
                wait_cnt <= WAIT_LOAD;
            else if (in_req && !wait_tc)
                wait_cnt <= wait_cnt - CW'(1);

            if ((state == S_DECODE) && is_bad)
                illegal <= 1'b1;
            if (in_req && (nxt == S_ERR))
                timeout <= 1'b1;

            if ((nxt == S_FETCH) &&
                ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)))
                retired <= retired + RET_W'(1);

            ALUOp      <= 3'b000;
            alu_src_b  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            reg_write  <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            busy       <= (nxt != S_IDLE) && (nxt != S_HALT) && (nxt != S_ERR);
            halted     <= (nxt == S_HALT);
            case (nxt)
                S_FETCH: mem_req <= 1'b1;
                S_EXEC: begin
                    if (is_r) begin
                        ALUOp     <= 3'b000;
                        alu_src_b <= 1'b0;
                    end else if (is_imm) begin
                        ALUOp     <= opcode[2:0];
                        alu_src_b <= 1'b1;
                    end else if (is_lw || is_sw) begin
                        ALUOp     <= 3'b010;
                        alu_src_b <= 1'b1;
                    end else if (is_beq) begin
                        ALUOp     <= 3'b110;
                        alu_src_b <= 1'b0;
                    end
                end
                S_MEM: begin
                    mem_req <= 1'b1;
                    mem_we  <= is_sw;
                end
                S_WB: begin
                    reg_write  <= 1'b1;
                    mem_to_reg <= is_lw;
                    reg_dst    <= is_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expected outputs.
module tb_multicycle_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    opcode;
    logic          zero;
    logic          mem_ack;
    logic [2:0]    ALUOp;
    logic          alu_src_b, ir_write, pc_write, pc_branch, mem_req, mem_we;
    logic          reg_write, reg_dst, mem_to_reg, busy, halted, illegal, timeout;
    logic [RW-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.RET_W(RW), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .ALUOp(ALUOp), .alu_src_b(alu_src_b),
        .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .busy(busy),
        .halted(halted), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    // {ALUOp, alu_src_b, mem_req, mem_we, reg_write, reg_dst, mem_to_reg, busy, halted}
    logic [10:0] mo;
    logic [2:0]  ml;
    assign mo = {ALUOp, alu_src_b, mem_req, mem_we, reg_write, reg_dst,
                 mem_to_reg, busy, halted};
    assign ml = {ir_write, pc_write, pc_branch};

    localparam logic [10:0] O_IDLE   = 11'b000_0_0_0_0_0_0_0_0;
    localparam logic [10:0] O_FETCH  = 11'b000_0_1_0_0_0_0_1_0;
    localparam logic [10:0] O_DEC    = 11'b000_0_0_0_0_0_0_1_0;
    localparam logic [10:0] O_EXR    = 11'b000_0_0_0_0_0_0_1_0;
    localparam logic [10:0] O_EXI3   = 11'b011_1_0_0_0_0_0_1_0;
    localparam logic [10:0] O_EXMEM  = 11'b010_1_0_0_0_0_0_1_0;
    localparam logic [10:0] O_EXBEQ  = 11'b110_0_0_0_0_0_0_1_0;
    localparam logic [10:0] O_MEMLW  = 11'b000_0_1_0_0_0_0_1_0;
    localparam logic [10:0] O_MEMSW  = 11'b000_0_1_1_0_0_0_1_0;
    localparam logic [10:0] O_WBR    = 11'b000_0_0_0_1_1_0_1_0;
    localparam logic [10:0] O_WBI    = 11'b000_0_0_0_1_0_0_1_0;
    localparam logic [10:0] O_WBLW   = 11'b000_0_0_0_1_0_1_1_0;
    localparam logic [10:0] O_HALT   = 11'b000_0_0_0_0_0_0_0_1;
    localparam logic [10:0] O_ERR    = 11'b000_0_0_0_0_0_0_0_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called while in FETCH: hold off ack for 'waits' cycles, then ack.
    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_wait", 32'(mo), 32'(O_FETCH));
            mem_ack = 1'b0;
            #1;
            chk("fetch_wait_strobe", 32'(ml), 32'b000);
            tick();
        end
        chk("fetch", 32'(mo), 32'(O_FETCH));
        mem_ack = 1'b1;
        #1;
        chk("fetch_ack_strobe", 32'(ml), 32'b110);
        tick();
        mem_ack = 1'b0;
    endtask

    // Called while in MEM.
    task automatic do_mem(input int waits, input logic [10:0] exp);
        for (int i = 0; i < waits; i++) begin
            chk("mem_wait", 32'(mo), 32'(exp));
            tick();
        end
        chk("mem", 32'(mo), 32'(exp));
        mem_ack = 1'b1;
        #1;
        chk("mem_ack_strobe", 32'(ml), 32'b000);
        tick();
        mem_ack = 1'b0;
    endtask

    // Full beq instruction starting and ending in FETCH.
    task automatic do_beq(input logic z);
        opcode = 4'hA;
        zero   = z;
        do_fetch(0);
        chk("beq_decode", 32'(mo), 32'(O_DEC));
        tick();
        chk("beq_exec", 32'(mo), 32'(O_EXBEQ));
        #1;
        chk("beq_branch", 32'(ml), {29'b0, 1'b0, 1'b0, z});
        tick();
        zero = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'(mo), 32'(O_IDLE));
        chk("rst_flags", {30'b0, illegal, timeout}, 32'b0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ack = 1'b0;
        repeat (2) tick();
        do_reset();
        chk("idle_after_reset", 32'(mo), 32'(O_IDLE));

        // R-type
        opcode = 4'h0;
        begin_run();
        do_fetch(1);
        chk("r_decode", 32'(mo), 32'(O_DEC));
        tick();
        chk("r_exec", 32'(mo), 32'(O_EXR));
        tick();
        chk("r_wb", 32'(mo), 32'(O_WBR));
        tick();
        chk("r_back_fetch", 32'(mo), 32'(O_FETCH));
        chk("r_retired", 32'(retired), 32'd1);

        // lw with delayed ack: MEM held 3 cycles
        opcode = 4'h8;
        do_fetch(1);
        chk("lw_decode", 32'(mo), 32'(O_DEC));
        tick();
        chk("lw_exec", 32'(mo), 32'(O_EXMEM));
        tick();
        do_mem(2, O_MEMLW);
        chk("lw_wb", 32'(mo), 32'(O_WBLW));
        chk("lw_not_retired_yet", 32'(retired), 32'd1);
        tick();
        chk("lw_retired", 32'(retired), 32'd2);

        // beq taken, then not taken
        do_beq(1'b1);
        chk("beq1_retired", 32'(retired), 32'd3);
        do_beq(1'b0);
        chk("beq2_retired", 32'(retired), 32'd4);

        // sw retires straight from MEM
        opcode = 4'h9;
        do_fetch(0);
        tick();
        chk("sw_exec", 32'(mo), 32'(O_EXMEM));
        tick();
        do_mem(0, O_MEMSW);
        chk("sw_back_fetch", 32'(mo), 32'(O_FETCH));
        chk("sw_retired", 32'(retired), 32'd5);

        // immediate op 0011
        opcode = 4'h3;
        do_fetch(0);
        tick();
        chk("imm_exec", 32'(mo), 32'(O_EXI3));
        tick();
        chk("imm_wb", 32'(mo), 32'(O_WBI));
        tick();
        chk("imm_retired", 32'(retired), 32'd6);

        // retire counter wraps at 2^RW
        for (int i = 0; i < 9; i++) do_beq(1'b0);
        chk("retired_max", 32'(retired), 32'd15);
        do_beq(1'b0);
        chk("retired_wrap", 32'(retired), 32'd0);

        // reset in the middle of a MEM request
        do_beq(1'b0);
        opcode = 4'h8;
        do_fetch(0);
        tick();
        tick();
        chk("mem_before_rst", 32'(mo), 32'(O_MEMLW));
        chk("retired_before_rst", 32'(retired), 32'd1);
        do_reset();
        chk("idle_after_mid_rst", 32'(mo), 32'(O_IDLE));

        // HALT is terminal
        opcode = 4'hF;
        begin_run();
        do_fetch(0);
        tick();
        chk("halt", 32'(mo), 32'(O_HALT));
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        chk("halt_stays", 32'(mo), 32'(O_HALT));
        do_reset();

        // fetch timeout: no ack for 64 cycles
        begin_run();
        for (int i = 0; i < 64; i++) begin
            if (i == 0 || i == 63) chk("to_waiting", 32'(mo), 32'(O_FETCH));
            tick();
        end
        chk("to_err", 32'(mo), 32'(O_ERR));
        chk("to_flags", {30'b0, illegal, timeout}, 32'b01);
        do_reset();

        // ack on the last allowed cycle wins
        begin_run();
        repeat (63) tick();
        chk("to_edge_fetch", 32'(mo), 32'(O_FETCH));
        opcode = 4'hC;
        mem_ack = 1'b1;
        #1;
        chk("to_edge_strobe", 32'(ml), 32'b110);
        tick();
        mem_ack = 1'b0;
        chk("to_edge_decode", 32'(mo), 32'(O_DEC));
        chk("to_edge_no_flag", 32'(timeout), 32'd0);

        // illegal opcode 1100 from that DECODE
        tick();
        chk("ill_err", 32'(mo), 32'(O_ERR));
        chk("ill_flags", {30'b0, illegal, timeout}, 32'b10);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        chk("ill_start_ignored", 32'(mo), 32'(O_ERR));
        chk("ill_sticky", 32'(illegal), 32'd1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
